// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port RAM arbiter.
// Consumers import mem_port_arbiter_pkg::*.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_MEM = 2'd2
    } arb_state_e;

    localparam logic [31:0] ZeroWord = 32'h0;

    localparam logic [1:0] GNT_IF  = 2'b01;
    localparam logic [1:0] GNT_MEM = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle between pipeline/RAM (master side) and the arbiter (slave side).
// The master side drives requests and the RAM read data.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    logic        ram_en;
    logic [3:0]  ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic        stall_if;
    logic        stall_mem;

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_be,
        output mem_addr, mem_wdata,
        output ram_rdata,
        input  if_rdata, if_valid,
        input  mem_rdata, mem_valid,
        input  ram_en, ram_we,
        input  ram_addr, ram_wdata,
        input  stall_if, stall_mem
    );

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_be,
        input  mem_addr, mem_wdata,
        input  ram_rdata,
        output if_rdata, if_valid,
        output mem_rdata, mem_valid,
        output ram_en, ram_we,
        output ram_addr, ram_wdata,
        output stall_if, stall_mem
    );

endinterface

// File: rtl/mem_port_arbiter_arb_lat_counter.sv
// Loadable down-counter timing the fixed RAM read latency.
// done is high whenever the count has reached zero.
module arb_lat_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: MEM has fixed priority over IF.
// Define MEM_ARB_PIPELINE_EN to issue the other requester in the completion cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int CntW = $clog2(MEM_LATENCY + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LATENCY - 1);

    arb_state_e  state_q, state_d;
    logic [1:0]  gnt;
    logic        cnt_done;
    logic        done_if, done_mem;
    logic [31:0] if_hold_q, mem_hold_q;
    logic        unused_addr_lsbs;

    // Alignment is enforced upstream; byte offsets are dropped here.
    assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.mem_addr[1:0]};

    arb_lat_counter #(
        .W(CntW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gnt != 2'b00),
        .load_val (CntLoad),
        .done     (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        done_if  = (state_q == ARB_BUSY_IF) && cnt_done;
        done_mem = (state_q == ARB_BUSY_MEM) && cnt_done;
        gnt      = 2'b00;
        case (state_q)
            ARB_IDLE: begin
                if (bus.mem_req) gnt = GNT_MEM;
                else if (bus.if_req) gnt = GNT_IF;
            end
`ifdef MEM_ARB_PIPELINE_EN
            // The finishing requester still holds req, so only the other may win.
            ARB_BUSY_IF: begin
                if (cnt_done && bus.mem_req) gnt = GNT_MEM;
            end
            ARB_BUSY_MEM: begin
                if (cnt_done && bus.if_req) gnt = GNT_IF;
            end
`endif
            default: gnt = 2'b00;
        endcase

        state_d = state_q;
        unique case (gnt)
            GNT_MEM: state_d = ARB_BUSY_MEM;
            GNT_IF:  state_d = ARB_BUSY_IF;
            default: begin
                if (done_if || done_mem) state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_hold_q  <= ZeroWord;
            mem_hold_q <= ZeroWord;
        end else begin
            if (done_if) if_hold_q <= bus.ram_rdata;
            if (done_mem) mem_hold_q <= bus.ram_rdata;
        end
    end

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 4'h0;
        bus.ram_addr  = 30'h0;
        bus.ram_wdata = ZeroWord;
        if (!rst) begin
            unique case (gnt)
                GNT_MEM: begin
                    bus.ram_en    = 1'b1;
                    bus.ram_we    = bus.mem_we ? bus.mem_be : 4'h0;
                    bus.ram_addr  = bus.mem_addr[31:2];
                    bus.ram_wdata = bus.mem_wdata;
                end
                GNT_IF: begin
                    bus.ram_en   = 1'b1;
                    bus.ram_addr = bus.if_addr[31:2];
                end
                default: ;
            endcase
        end
    end

    assign bus.if_valid  = done_if & ~rst;
    assign bus.mem_valid = done_mem & ~rst;

    assign bus.if_rdata  = rst      ? ZeroWord      :
                           done_if  ? bus.ram_rdata : if_hold_q;
    assign bus.mem_rdata = rst      ? ZeroWord      :
                           done_mem ? bus.ram_rdata : mem_hold_q;

    assign bus.stall_if  = bus.if_req & ~done_if & ~rst;
    assign bus.stall_mem = bus.mem_req & ~done_mem & ~rst;

endmodule
